// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and defaults for the ibus/dbus Wishbone arbiter
package wb_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_CYC_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ERR   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    function automatic arb_state_t grant_state(input owner_t own);
        return (own == OWN_D) ? GNT_D : GNT_I;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stalled-cycle counter; expired_o flags the cycle whose count reaches TIMEOUT_CYC
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_wdg;
            assign unused_wdg = ^{clk, rst, clr_i, en_i};
            assign expired_o  = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

            logic [CNT_W-1:0] count_q;
            logic [CNT_W-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clr_i) begin
                    count_d = '0;
                end else if (en_i) begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            // Expiry is flagged in the stalled cycle that would make the count reach
            // TIMEOUT_CYC, so an ack in that same cycle (en_i low) always wins.
            assign expired_o = en_i && !clr_i && (count_q == CNT_W'(TIMEOUT_CYC - 1));
        end
    endgenerate

endmodule

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - ibus/dbus to single Wishbone slave arbiter; WB_ARB_RR_EN selects round-robin tie-break
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_cyc_i,
    input  logic                  i_stb_i,
    input  logic                  i_we_i,
    input  logic [ADDR_W-1:0]     i_adr_i,
    input  logic [DATA_W-1:0]     i_dat_i,
    input  logic [DATA_W/8-1:0]   i_sel_i,
    output logic [DATA_W-1:0]     i_dat_o,
    output logic                  i_ack_o,
    output logic                  i_err_o,

    input  logic                  d_cyc_i,
    input  logic                  d_stb_i,
    input  logic                  d_we_i,
    input  logic [ADDR_W-1:0]     d_adr_i,
    input  logic [DATA_W-1:0]     d_dat_i,
    input  logic [DATA_W/8-1:0]   d_sel_i,
    output logic [DATA_W-1:0]     d_dat_o,
    output logic                  d_ack_o,
    output logic                  d_err_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_W-1:0]     s_adr_o,
    output logic [DATA_W-1:0]     s_dat_o,
    output logic [DATA_W/8-1:0]   s_sel_o,
    input  logic [DATA_W-1:0]     s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i
);

    arb_state_t state_q;
    owner_t     err_own_q;

    logic i_req;
    logic d_req;
    logic d_wins;
    logic in_gnt;
    logic wdg_en;
    logic wdg_clr;
    logic wdg_expired;

    assign i_req  = i_cyc_i & i_stb_i;
    assign d_req  = d_cyc_i & d_stb_i;
    assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);

`ifdef WB_ARB_RR_EN
    owner_t last_own_q;

    // On a tie the master that did not hold the bus last goes first.
    assign d_wins = (last_own_q == OWN_I);
`else
    assign d_wins = 1'b1;
`endif

    // Count only cycles where the slave is being strobed and has not terminated.
    assign wdg_en  = in_gnt && s_stb_o && !s_ack_i && !s_err_i;
    assign wdg_clr = !in_gnt || s_ack_i || s_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wdg_clr),
        .en_i      (wdg_en),
        .expired_o (wdg_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            err_own_q  <= OWN_I;
`ifdef WB_ARB_RR_EN
            last_own_q <= OWN_D;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (d_req && (!i_req || d_wins)) begin
                        state_q    <= GNT_D;
`ifdef WB_ARB_RR_EN
                        last_own_q <= OWN_D;
`endif
                    end else if (i_req) begin
                        state_q    <= GNT_I;
`ifdef WB_ARB_RR_EN
                        last_own_q <= OWN_I;
`endif
                    end
                end
                GNT_I: begin
                    if (!i_cyc_i) begin
                        state_q <= IDLE;
                    end else if (wdg_expired) begin
                        state_q   <= ERR;
                        err_own_q <= OWN_I;
                    end
                end
                GNT_D: begin
                    if (!d_cyc_i) begin
                        state_q <= IDLE;
                    end else if (wdg_expired) begin
                        state_q   <= ERR;
                        err_own_q <= OWN_D;
                    end
                end
                ERR: begin
                    // Owner keeps the bus after the forced error if it still holds cyc.
                    if (err_own_q == OWN_D) begin
                        state_q <= d_cyc_i ? grant_state(OWN_D) : IDLE;
                    end else begin
                        state_q <= i_cyc_i ? grant_state(OWN_I) : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Slave-side mux and termination routing; everything is held low while rst is high.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        i_ack_o = 1'b0;
        i_err_o = 1'b0;
        d_ack_o = 1'b0;
        d_err_o = 1'b0;
        i_dat_o = s_dat_i;
        d_dat_o = s_dat_i;
        if (!rst) begin
            case (state_q)
                GNT_I: begin
                    s_cyc_o = i_cyc_i;
                    s_stb_o = i_stb_i;
                    s_we_o  = i_we_i;
                    s_adr_o = i_adr_i;
                    s_dat_o = i_dat_i;
                    s_sel_o = i_sel_i;
                    i_ack_o = s_ack_i;
                    i_err_o = s_err_i;
                end
                GNT_D: begin
                    s_cyc_o = d_cyc_i;
                    s_stb_o = d_stb_i;
                    s_we_o  = d_we_i;
                    s_adr_o = d_adr_i;
                    s_dat_o = d_dat_i;
                    s_sel_o = d_sel_i;
                    d_ack_o = s_ack_i;
                    d_err_o = s_err_i;
                end
                ERR: begin
                    i_err_o = (err_own_q == OWN_I);
                    d_err_o = (err_own_q == OWN_D);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed self-checking bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        i_cyc_i, i_stb_i, i_we_i;
    logic [31:0] i_adr_i, i_dat_i;
    logic [3:0]  i_sel_i;
    logic [31:0] i_dat_o;
    logic        i_ack_o, i_err_o;
    logic        d_cyc_i, d_stb_i, d_we_i;
    logic [31:0] d_adr_i, d_dat_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_dat_o;
    logic        d_ack_o, d_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;

    int checks;
    int failures;

    wb_bus_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk     (clk),     .rst     (rst),
        .i_cyc_i (i_cyc_i), .i_stb_i (i_stb_i), .i_we_i  (i_we_i),
        .i_adr_i (i_adr_i), .i_dat_i (i_dat_i), .i_sel_i (i_sel_i),
        .i_dat_o (i_dat_o), .i_ack_o (i_ack_o), .i_err_o (i_err_o),
        .d_cyc_i (d_cyc_i), .d_stb_i (d_stb_i), .d_we_i  (d_we_i),
        .d_adr_i (d_adr_i), .d_dat_i (d_dat_i), .d_sel_i (d_sel_i),
        .d_dat_o (d_dat_o), .d_ack_o (d_ack_o), .d_err_o (d_err_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; i_cyc_i = 1'b1; i_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
        repeat (2) nxt();
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rst_s_cyc got=%0h exp=0", s_cyc_o); end
        checks++; if (s_stb_o !== 1'b0) begin failures++; $display("FAIL rst_s_stb got=%0h exp=0", s_stb_o); end
        checks++; if (i_ack_o !== 1'b0) begin failures++; $display("FAIL rst_i_ack got=%0h exp=0", i_ack_o); end
        checks++; if ({i_err_o, d_err_o, d_ack_o} !== 3'b000) begin failures++; $display("FAIL rst_err_ack got=%0h exp=0", {i_err_o, d_err_o, d_ack_o}); end
        nxt();
        rst = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%0h exp=0", s_cyc_o); end
    endtask

    task automatic test_ibus_read;
        nxt();
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_we_i = 1'b0; i_adr_i = 32'h100; i_sel_i = 4'hF;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rd_arb_latency got=%0h exp=0", s_cyc_o); end
        nxt();
        smp();
        checks++; if (s_cyc_o !== 1'b1) begin failures++; $display("FAIL rd_grant got=%0h exp=1", s_cyc_o); end
        checks++; if (s_adr_o !== 32'h100) begin failures++; $display("FAIL rd_adr got=%h exp=00000100", s_adr_o); end
        checks++; if (i_ack_o !== 1'b0) begin failures++; $display("FAIL rd_early_ack got=%0h exp=0", i_ack_o); end
        nxt();
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        smp();
        checks++; if (i_ack_o !== 1'b1) begin failures++; $display("FAIL rd_ack got=%0h exp=1", i_ack_o); end
        checks++; if (i_dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", i_dat_o); end
        checks++; if (d_ack_o !== 1'b0) begin failures++; $display("FAIL rd_d_ack got=%0h exp=0", d_ack_o); end
        nxt();
        s_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rd_release got=%0h exp=0", s_cyc_o); end
        nxt();
    endtask

    task automatic test_priority;
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h100;
        d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h200; d_we_i = 1'b0; d_sel_i = 4'hF;
        nxt();
        smp();
        checks++; if (s_adr_o !== 32'h200) begin failures++; $display("FAIL prio_d_first got=%h exp=00000200", s_adr_o); end
        nxt();
        s_ack_i = 1'b1;
        smp();
        checks++; if ({d_ack_o, i_ack_o} !== 2'b10) begin failures++; $display("FAIL prio_ack_route got=%b exp=10", {d_ack_o, i_ack_o}); end
        nxt();
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL prio_d_drop got=%0h exp=0", s_cyc_o); end
        nxt();
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL prio_idle_gap got=%0h exp=0", s_cyc_o); end
        nxt();
        smp();
        checks++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL prio_i_second got=%h exp=100000100", {s_cyc_o, s_adr_o}); end
        nxt();
        s_ack_i = 1'b1;
        smp();
        checks++; if (i_ack_o !== 1'b1) begin failures++; $display("FAIL prio_i_ack got=%0h exp=1", i_ack_o); end
        nxt();
        s_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        nxt();
    endtask

    task automatic test_burst;
        d_cyc_i = 1'b1; d_stb_i = 1'b1; d_we_i = 1'b1; d_sel_i = 4'hF;
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h100;
        nxt();
        for (int b = 0; b < 4; b++) begin
            d_adr_i = 32'h300 + 32'(4 * b); d_dat_i = 32'hA0 + 32'(b); s_ack_i = 1'b1;
            smp();
            checks++; if ({d_ack_o, i_ack_o} !== 2'b10) begin failures++; $display("FAIL burst_ack beat=%0d got=%b exp=10", b, {d_ack_o, i_ack_o}); end
            checks++; if ({s_we_o, s_adr_o, s_dat_o} !== {1'b1, 32'h300 + 32'(4 * b), 32'hA0 + 32'(b)}) begin failures++; $display("FAIL burst_wr beat=%0d got=%h", b, {s_we_o, s_adr_o, s_dat_o}); end
            nxt();
        end
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0;
        smp();
        checks++; if ({s_cyc_o, i_ack_o} !== 2'b00) begin failures++; $display("FAIL burst_end got=%b exp=00", {s_cyc_o, i_ack_o}); end
        nxt();
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL burst_gap got=%0h exp=0", s_cyc_o); end
        nxt();
        smp();
        checks++; if ({s_cyc_o, s_we_o, s_adr_o} !== {2'b10, 32'h100}) begin failures++; $display("FAIL burst_i_grant got=%h", {s_cyc_o, s_we_o, s_adr_o}); end
        nxt();
        s_ack_i = 1'b1;
        nxt();
        s_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        nxt();
    endtask

    task automatic test_rr;
        logic [31:0] exp_adr;
`ifdef WB_ARB_RR_EN
        exp_adr = 32'h100;
`else
        exp_adr = 32'h200;
`endif
        d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h200;
        nxt();
        s_ack_i = 1'b1;
        smp();
        checks++; if (d_ack_o !== 1'b1) begin failures++; $display("FAIL rr_d_ack got=%0h exp=1", d_ack_o); end
        nxt();
        s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        nxt();
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h100;
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        nxt();
        smp();
        checks++; if (s_adr_o !== exp_adr) begin failures++; $display("FAIL rr_tie_winner got=%h exp=%h", s_adr_o, exp_adr); end
        nxt();
        i_cyc_i = 1'b0; i_stb_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_abort got=%0h exp=0", s_cyc_o); end
        nxt();
    endtask

    task automatic test_timeout;
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h100;
        nxt();
        for (int k = 0; k < 8; k++) begin
            smp();
            checks++; if ({s_cyc_o, i_err_o} !== 2'b10) begin failures++; $display("FAIL to_wait k=%0d got=%b exp=10", k, {s_cyc_o, i_err_o}); end
            nxt();
        end
        smp();
        checks++; if (i_err_o !== 1'b1) begin failures++; $display("FAIL to_err got=%0h exp=1", i_err_o); end
        checks++; if ({s_cyc_o, s_stb_o, d_err_o} !== 3'b000) begin failures++; $display("FAIL to_err_bus got=%b exp=000", {s_cyc_o, s_stb_o, d_err_o}); end
        nxt();
        smp();
        checks++; if ({s_cyc_o, i_err_o} !== 2'b10) begin failures++; $display("FAIL to_regrant got=%b exp=10", {s_cyc_o, i_err_o}); end
        repeat (7) nxt();
        s_ack_i = 1'b1;
        smp();
        checks++; if ({i_ack_o, i_err_o} !== 2'b10) begin failures++; $display("FAIL to_ack_wins got=%b exp=10", {i_ack_o, i_err_o}); end
        nxt();
        s_ack_i = 1'b0; i_cyc_i = 1'b0; i_stb_i = 1'b0;
        smp();
        checks++; if ({s_cyc_o, i_err_o} !== 2'b00) begin failures++; $display("FAIL to_no_err got=%b exp=00", {s_cyc_o, i_err_o}); end
        nxt();
    endtask

    task automatic test_abort;
        d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h400;
        repeat (6) nxt();
        d_cyc_i = 1'b0; d_stb_i = 1'b0;
        smp();
        checks++; if ({s_cyc_o, d_err_o} !== 2'b00) begin failures++; $display("FAIL abort_same_cycle got=%b exp=00", {s_cyc_o, d_err_o}); end
        nxt();
        d_cyc_i = 1'b1; d_stb_i = 1'b1;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL abort_idle got=%0h exp=0", s_cyc_o); end
        nxt();
        for (int k = 0; k < 8; k++) begin
            smp();
            checks++; if (d_err_o !== 1'b0) begin failures++; $display("FAIL abort_wdg_clr k=%0d got=%0h exp=0", k, d_err_o); end
            nxt();
        end
        smp();
        checks++; if ({d_err_o, i_err_o} !== 2'b10) begin failures++; $display("FAIL abort_d_err got=%b exp=10", {d_err_o, i_err_o}); end
        nxt();
        d_cyc_i = 1'b0; d_stb_i = 1'b0;
        nxt();
    endtask

    task automatic test_rst_mid;
        d_cyc_i = 1'b1; d_stb_i = 1'b1; d_adr_i = 32'h500;
        nxt();
        i_cyc_i = 1'b1; i_stb_i = 1'b1; i_adr_i = 32'h100;
        smp();
        checks++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h500}) begin failures++; $display("FAIL rstm_grant got=%h", {s_cyc_o, s_adr_o}); end
        nxt();
        rst = 1'b1; s_ack_i = 1'b1;
        smp();
        checks++; if ({d_ack_o, i_ack_o} !== 2'b00) begin failures++; $display("FAIL rstm_no_ack got=%b exp=00", {d_ack_o, i_ack_o}); end
        nxt();
        rst = 1'b0; s_ack_i = 1'b0; d_cyc_i = 1'b0; d_stb_i = 1'b0;
        smp();
        checks++; if (s_cyc_o !== 1'b0) begin failures++; $display("FAIL rstm_idle got=%0h exp=0", s_cyc_o); end
        nxt();
        smp();
        checks++; if ({s_cyc_o, s_adr_o} !== {1'b1, 32'h100}) begin failures++; $display("FAIL rstm_i_grant got=%h", {s_cyc_o, s_adr_o}); end
        nxt();
        i_cyc_i = 1'b0; i_stb_i = 1'b0;
        nxt();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        i_cyc_i = 1'b0; i_stb_i = 1'b0; i_we_i = 1'b0; i_adr_i = '0; i_dat_i = '0; i_sel_i = '0;
        d_cyc_i = 1'b0; d_stb_i = 1'b0; d_we_i = 1'b0; d_adr_i = '0; d_dat_i = '0; d_sel_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        test_reset();
        test_ibus_read();
        test_priority();
        test_burst();
        test_rr();
        test_timeout();
        test_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Shares one Wishbone slave port (unified memory / system bus) between the CPU instruction master (ibus) and data master (dbus).
- Sits between the CPU core and the memory/peripheral fabric, in the assembled CPU top.
- Grants one master at a time and holds the grant until that master drops cyc.
- A watchdog terminates hung slave cycles with an error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; SEL_W is fixed at DATA_W/8.
- TIMEOUT_CYC, 255, cycles without slave ack before forced error; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_cyc_i, i_stb_i, i_we_i  in  1 each  ibus master strobes.
- i_adr_i  in  ADDR_W  ibus address.
- i_dat_i  in  DATA_W  ibus write data.
- i_sel_i  in  SEL_W  ibus byte select.
- i_dat_o  out  DATA_W  ibus read data.
- i_ack_o, i_err_o  out  1 each  ibus termination.
- d_cyc_i, d_stb_i, d_we_i, d_adr_i, d_dat_i, d_sel_i, d_dat_o, d_ack_o, d_err_o  same as ibus, for dbus.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave strobes.
- s_adr_o  out  ADDR_W  slave address.
- s_dat_o  out  DATA_W  slave write data.
- s_sel_o  out  SEL_W  slave byte select.
- s_dat_i  in  DATA_W  slave read data.
- s_ack_i, s_err_i  in  1 each  slave termination.

Behaviour:
- Registered FSM with states IDLE, GNT_I, GNT_D, ERR. Reset (sync, rst=1) forces IDLE, watchdog count 0, and all s_*_o, *_ack_o and *_err_o to 0.
- IDLE:
  - request = cyc_i & stb_i.
  - dbus requesting -> GNT_D; else ibus requesting -> GNT_I.
  - Fixed priority, dbus wins on simultaneous requests.
  - Decision is registered at edge N; the slave sees the request from cycle N+1, giving 1 cycle arbitration latency.
- GNT_x:
  - Slave outputs are combinationally muxed from master x, with s_cyc_o = x_cyc_i and s_stb_o = x_stb_i.
  - s_ack_i/s_err_i route combinationally to x_ack_o/x_err_o. s_dat_i drives both *_dat_o; the other master's ack/err stay 0.
  - Grant is held while x_cyc_i=1, so back-to-back or block transfers stay locked.
  - x_cyc_i=0 -> IDLE next cycle, and s_cyc_o drops in the same cycle as x_cyc_i (abort supported).
  - The other master is not arbitrated until return to IDLE, giving a minimum 1 idle cycle between owners.
- Watchdog:
  - Counter increments each cycle in GNT_x with s_stb_o=1 and s_ack_i=0, s_err_i=0.
  - Counter clears on ack, err, or leaving GNT_x.
  - Reaching TIMEOUT_CYC -> ERR.
  - Ack and expiry in the same cycle -> ack wins, no ERR.
- ERR:
  - s_cyc_o=0, s_stb_o=0; x_err_o=1 for exactly one cycle to the owning master.
  - Then GNT_x if x_cyc_i still 1, else IDLE.
- Read data is not registered: a master samples *_dat_o only with its own ack.
- rst asserted mid-transfer -> IDLE next edge, s_cyc_o=0 from that cycle, no ack/err generated.

Optional Feature:
- Macro WB_ARB_RR_EN.
- When defined: a 1-bit last-owner register (reset = dbus) selects the winner on simultaneous requests. Priority goes to the master that did not own the bus last; a single requester is always granted.
- When undefined: fixed dbus-over-ibus priority, and the register is not instantiated.

Decomposition:
- Package wb_arb_pkg holds:
  - state enum arb_state_t {IDLE, GNT_I, GNT_D, ERR};
  - owner enum {OWN_I, OWN_D};
  - default width localparams.
- One natural sub-module, wb_arb_watchdog: counter with clear, enable and expired output, parameterised by TIMEOUT_CYC.
- The top instantiates the FSM and output muxes.

Test Plan:
- Single ibus read of adr 0x100, slave acks on its 2nd stb cycle with 0xDEADBEEF -> s_cyc_o rises 1 cycle after i_cyc_i; i_dat_o=0xDEADBEEF with i_ack_o; d_ack_o stays 0.
- Simultaneous i/d requests at cycle 0 -> dbus served first. ibus is granted only after d_cyc_i drops plus 1 idle cycle (without RR). With WB_ARB_RR_EN and a prior dbus owner -> ibus served first.
- dbus 4-beat write burst with cyc held -> ibus requesting throughout is not granted until burst end; all 4 s_ack_i route only to d_ack_o.
- TIMEOUT_CYC=8, slave never acks -> i_err_o=1 exactly one cycle, 8 cycles after stb is seen at the slave; s_cyc_o=0 during ERR; ack and expiry on the same cycle gives ack, no err.
- rst pulsed while GNT_D mid-transfer -> next cycle s_cyc_o=0 and state IDLE; a pending ibus request is granted 1 cycle after rst deasserts.
- Master aborts (cyc drops without ack) -> s_cyc_o=0 the same cycle, IDLE next cycle, watchdog count cleared.
